// File: rtl/dcp_pkg.sv
// Shared constants, state encoding and helpers for the serial debug command dispatcher.
package dcp_pkg;

  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_T = 8'h54;

  localparam logic [7:0] CH_QM = 8'h3F;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [1:0] SLOT_D = 2'd0;
  localparam logic [1:0] SLOT_I = 2'd1;
  localparam logic [1:0] SLOT_R = 2'd2;
  localparam logic [1:0] SLOT_T = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_GRANT = 3'd2,
    S_ERR   = 3'd3,
    S_DONE  = 3'd4
  } dispatch_state_t;

  // Character of the "?\r\n" error reply at position cnt.
  function automatic logic [7:0] err_char(input logic [1:0] cnt);
    case (cnt)
      2'd0:    err_char = CH_QM;
      2'd1:    err_char = CH_CR;
      2'd2:    err_char = CH_LF;
      default: err_char = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/dcp_cmd_decode.sv
// Maps an ASCII command byte onto its processor slot; uppercase only.
module dcp_cmd_decode
  import dcp_pkg::*;
(
  input  logic [7:0] sel_mode,
  output logic       hit,
  output logic [1:0] slot
);

  always_comb begin
    hit  = 1'b1;
    slot = SLOT_D;
    case (sel_mode)
      CMD_D:   slot = SLOT_D;
      CMD_I:   slot = SLOT_I;
      CMD_R:   slot = SLOT_R;
      CMD_T:   slot = SLOT_T;
      default: hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/dcp_dispatch.sv
// Command dispatcher: grants the shared UART engines to one command slot at a time,
// answers unknown commands with "?\r\n" and recovers hung slots via a watchdog.
module dcp_dispatch
  import dcp_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [7:0]       sel_mode,
  output logic             busy,
  output logic             cmd_done,
  output logic             timeout,
  output logic [3:0]       start,
  input  logic [3:0]       finish,
  input  logic [3:0]       req_tx_i,
  input  logic [3:0]       type_tx_i,
  input  logic [3:0][31:0] dout_i,
  output logic [3:0]       ack_tx_o,
  input  logic [3:0]       req_rx_i,
  input  logic [3:0]       type_rx_i,
  output logic [3:0]       ack_rx_o,
  output logic             req_tx,
  output logic             type_tx,
  output logic [31:0]      dout_tx,
  input  logic             ack_tx,
  output logic             req_rx,
  output logic             type_rx,
  input  logic             ack_rx
);

  dispatch_state_t      state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic [1:0]           err_cnt_q, err_cnt_d;
  logic                 err_req_q, err_req_d;
  logic                 to_flag_q, to_flag_d;
  logic [3:0]           start_q, start_d;
  logic                 cmd_done_q, cmd_done_d;
  logic                 timeout_q, timeout_d;
  logic                 dec_hit;
  logic [1:0]           dec_slot;

  dcp_cmd_decode u_decode (
    .sel_mode (sel_mode),
    .hit      (dec_hit),
    .slot     (dec_slot)
  );

  assign wd_inc = wd_q + TIMEOUT_W'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wd_d       = wd_q;
    err_cnt_d  = err_cnt_q;
    err_req_d  = err_req_q;
    to_flag_d  = to_flag_q;
    start_d    = 4'b0000;
    cmd_done_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (dec_hit) begin
            owner_d = dec_slot;
            state_d = S_START;
          end else begin
            err_cnt_d = 2'd0;
            err_req_d = 1'b1;
            state_d   = S_ERR;
          end
        end
      end
      S_START: begin
        start_d   = 4'b0001 << owner_q;
        wd_d      = '0;
        to_flag_d = 1'b0;
        state_d   = S_GRANT;
      end
      S_GRANT: begin
        if (wd_q != '1) wd_d = wd_inc;
        // Expiry when the count is about to hit all-ones: GRANT lasts 2^TIMEOUT_W-1 cycles.
        if (finish[owner_q]) begin
          state_d = S_DONE;
        end else if (wd_inc == '1) begin
          to_flag_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_ERR: begin
        if (ack_tx && err_req_q) begin
          err_req_d = 1'b0;
          if (err_cnt_q == 2'd2) state_d = S_DONE;
          else err_cnt_d = err_cnt_q + 2'd1;
        end else begin
          err_req_d = 1'b1;
        end
      end
      S_DONE: begin
        cmd_done_d = 1'b1;
        timeout_d  = to_flag_q;
        to_flag_d  = 1'b0;
        err_req_d  = 1'b0;
        owner_d    = SLOT_D;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= SLOT_D;
      wd_q       <= '0;
      err_cnt_q  <= 2'd0;
      err_req_q  <= 1'b0;
      to_flag_q  <= 1'b0;
      start_q    <= 4'b0000;
      cmd_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wd_q       <= wd_d;
      err_cnt_q  <= err_cnt_d;
      err_req_q  <= err_req_d;
      to_flag_q  <= to_flag_d;
      start_q    <= start_d;
      cmd_done_q <= cmd_done_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    req_tx   = 1'b0;
    type_tx  = 1'b0;
    dout_tx  = 32'h0;
    req_rx   = 1'b0;
    type_rx  = 1'b0;
    ack_tx_o = 4'b0000;
    ack_rx_o = 4'b0000;
    if (state_q == S_GRANT) begin
      req_tx            = req_tx_i[owner_q];
      type_tx           = type_tx_i[owner_q];
      dout_tx           = dout_i[owner_q];
      req_rx            = req_rx_i[owner_q];
      type_rx           = type_rx_i[owner_q];
      ack_tx_o[owner_q] = ack_tx;
      ack_rx_o[owner_q] = ack_rx;
    end else if (state_q == S_ERR) begin
      req_tx  = err_req_q;
      dout_tx = {24'h0, err_char(err_cnt_q)};
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign start    = start_q;
  assign cmd_done = cmd_done_q;
  assign timeout  = timeout_q;

endmodule

// File: doc/dcp_dispatch.md
# dcp_dispatch

Command dispatcher and serial-port arbiter for the serial debug unit. Decodes the command byte from the main controller, grants exclusive use of the shared UART RX and TX engines to exactly one command processor (D, I, R, T slots), and routes handshakes until that processor raises its finish flag. It answers unknown commands itself with `?` CR LF and recovers hung processors with a watchdog.

## Interface
Parameters:
- `TIMEOUT_W`, 24: watchdog counter width. Timeout fires after 2^TIMEOUT_W − 1 cycles in GRANT.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: one-cycle pulse; `sel_mode` holds a new command byte.
- `sel_mode` in 8: ASCII command byte.
- `busy` out 1: high in any state except IDLE.
- `cmd_done` out 1: one-cycle pulse when a command completes (normally, by error reply, or by timeout).
- `timeout` out 1: one-cycle pulse coincident with `cmd_done` when the watchdog fired.
- `start` out 4: one-hot, one-cycle start pulse to the selected slot.
- `finish` in 4: per-slot finish flags; level or pulse.
- `req_tx_i`, `type_tx_i` in 4 each; `dout_i` in 4×32: per-slot TX requests.
- `ack_tx_o` out 4: per-slot TX ack.
- `req_rx_i`, `type_rx_i` in 4 each: per-slot RX requests.
- `ack_rx_o` out 4: per-slot RX ack.
- `req_tx`, `type_tx` out 1 each; `dout_tx` out 32: to the TX engine.
- `ack_tx` in 1: TX engine ack (one-cycle pulse).
- `req_rx`, `type_rx` out 1 each: to the RX engine.
- `ack_rx` in 1: RX engine ack (one-cycle pulse). `din_rx` and `flag_rx` are wired directly to all slots and do not pass through this block.

## Operation
- Slot map (fixed): 0 = `D` (0x44), 1 = `I` (0x49), 2 = `R` (0x52), 3 = `T` (0x54). Lowercase is not accepted.
- States: IDLE, START, GRANT, ERR, DONE.
  - IDLE: on `cmd_valid`, decode `sel_mode`. A match latches `owner` (2 bits) and goes to START. No match goes to ERR with `err_cnt` = 0. `cmd_valid` is ignored in every other state.
  - START: assert `start[owner]` for 1 cycle, clear the watchdog, go to GRANT.
  - GRANT: route the owner's signals combinationally: `req_tx` = `req_tx_i[owner]`, `type_tx` = `type_tx_i[owner]`, `dout_tx` = `dout_i[owner]`, and likewise for RX; `ack_tx_o[owner]` = `ack_tx`, `ack_rx_o[owner]` = `ack_rx`. Non-owner acks stay 0 and non-owner requests are ignored. `finish[owner]` goes to DONE. The watchdog reaching all-ones goes to DONE with `timeout` asserted. Watchdog increments every GRANT cycle and saturates.
  - ERR: drive `type_tx` = 0 and `req_tx` = 1, with `dout_tx` = 0x3F, 0x0D, 0x0A for `err_cnt` = 0, 1, 2. Each `ack_tx` drops `req_tx` for 1 cycle and advances `err_cnt`. The ack on `err_cnt` = 2 goes to DONE.
  - DONE: pulse `cmd_done` for 1 cycle, clear `owner` routing, go to IDLE.
- Outside GRANT and ERR: `req_tx` = `req_rx` = 0 and all per-slot acks = 0.
- `type_rx` = 0 outside GRANT.

## Timing
- Reset values: state IDLE; `busy`, `cmd_done`, `timeout`, `start`, `req_tx`, `type_tx`, `req_rx`, `type_rx` = 0; `dout_tx` = 0; `ack_*_o` = 0; `owner` = 0; watchdog = 0.
- Latency:
  - `cmd_valid` to `start` pulse: 2 cycles (IDLE → START registered).
  - `finish` to `cmd_done`: 2 cycles.
  - GRANT routing adds 0 cycles; it is purely combinational, muxed on the registered `owner`.
- Handshakes:
  - Requesters hold `req` until `ack`.
  - The engine acks for exactly 1 cycle.
  - In ERR, `req_tx` is registered and deasserts the cycle after ack, so one ack never counts twice.
- Simultaneous events:
  - `finish[owner]` and watchdog expiry in the same cycle: finish wins, `timeout` = 0.
  - `finish` from a non-owner: ignored.
  - `ack_tx` in the same cycle as the transition to DONE: still forwarded to the owner.
- Reset mid-command: all requests drop immediately (asynchronous). The slot's own reset clears the slot.

## Structure
- Package `dcp_pkg`:
  - Command byte constants `CMD_D`, `CMD_I`, `CMD_R`, `CMD_T`.
  - Characters `CH_QM` (0x3F), `CH_CR` (0x0D), `CH_LF` (0x0A).
  - State enum `dispatch_state_t`.
  - Slot index constants.
- One natural sub-module, `dcp_cmd_decode`: combinational byte → {hit, slot}.

## Test plan
- `sel_mode` = 0x44 with `cmd_valid` → `start` = 4'b0001 two cycles later. Slot 0 TX request `dout` = 0x0000_0044 appears on `dout_tx`; `ack_tx` reaches only `ack_tx_o[0]`. `finish[0]` → `cmd_done` 2 cycles later, `busy` falls.
- `sel_mode` = 0x5A → TX sequence 0x3F, 0x0D, 0x0A, each held until ack → `cmd_done`; `start` stays 0.
- During a slot-2 grant, slot 1 asserts `req_tx_i` and `finish[1]` → `req_tx` follows slot 2 only, no `cmd_done`. A second `cmd_valid` mid-grant is ignored.
- `TIMEOUT_W` = 4, slot 3 never finishes → `cmd_done` and `timeout` pulse together 15 cycles after entering GRANT.
- `finish[owner]` in the same cycle as watchdog expiry → `cmd_done` = 1, `timeout` = 0.
- `rst` asserted during ERR after the first ack → `req_tx` = 0 immediately. The next 0x49 command executes normally.
